seg7_scan_scheduler: RTL
========================

Name: seg7_scan_scheduler

Overview:
- Time-multiplexing scheduler for the board's multi-digit 7-segment display.
- Double-buffers an 8-digit BCD frame from the game-logic side and strobes one digit at a time.
- Inserts an all-anodes-off guard interval between digits to prevent ghosting, and supports leading-zero blanking.
- Drives the anode lines directly; feeds the selected BCD nibble to the downstream BCD-to-segment decoder.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (anode width).
- TICK_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); TICK_DIV > BLANK_CYCLES.
- BLANK_CYCLES, 1000, guard cycles per slot with all anodes off; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan; 0 = display dark, scheduler idle.
- blank_lz  in  1  1 = suppress leading zeros.
- digits_in  in  4*NUM_DIGITS  BCD frame; nibble i = digit i, digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- digits_valid  in  1  producer offers digits_in/dp_in.
- digits_ready  out  1  staging buffer free.
- anode  out  NUM_DIGITS  active-low digit enables.
- digit_out  out  4  BCD nibble of the current digit.
- dp_out  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset: anode all 1, digit_out 0, dp_out 1, frame_done 0, digits_ready 1; active and staging buffers 0; pending 0; index 0; slot counter 0; state IDLE. All outputs are registered.
- States:
  - IDLE: anodes off. If enable=1, go to BLANK with index 0.
  - BLANK: lasts BLANK_CYCLES cycles, anodes off. digit_out/dp_out hold the active nibble and ~dp for the current index from the first BLANK cycle.
  - SHOW: lasts TICK_DIV-BLANK_CYCLES cycles. anode[index]=0 and all others 1, unless the digit is blanked.
  - After SHOW, index increments and the state returns to BLANK. Index wraps from NUM_DIGITS-1 to 0.
- Frame length is exactly NUM_DIGITS*TICK_DIV cycles.
- Frame boundary = last cycle of SHOW at index NUM_DIGITS-1. frame_done=1 in the following cycle, which is the first BLANK cycle of index 0.
- Leading-zero blanking:
  - Digit i (i != 0) is blanked when blank_lz=1 and active nibbles NUM_DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps all anodes off for its SHOW but consumes full slot timing. dp_out is 1 while blanked.
- Nibbles 10-15 pass through unchanged; no saturation.
- Load handshake:
  - Transfer occurs when digits_valid && digits_ready: digits_in/dp_in go into staging, pending=1, and digits_ready drops the next cycle.
  - At the frame boundary, staging is copied to active, pending is cleared, and digits_ready rises the next cycle.
  - If a transfer coincides with the boundary cycle while not pending, the data is written straight to active and pending stays 0.
  - In IDLE, a transfer is written straight to active; no staging is used.
  - The active buffer never changes mid-frame.
- enable deassert in any state: next cycle the state is IDLE, anodes are all 1, index and slot counter are 0, and frame_done is 0. Buffers and pending are retained. A pending frame is applied at the first boundary after re-enable.
- rst_n assertion mid-frame: immediate return to reset values, with no glitch on anode beyond going all-1.

Test Plan (NUM_DIGITS=8, TICK_DIV=10, BLANK_CYCLES=2):
1. Reset then enable=1, load 0x87654321 in IDLE.
   - Check: anode[0]=0 for cycles 3-10 after enable and all 1 in cycles 1-2.
   - Check: digit_out=1, then anode[1] active with digit_out=2.
   - Check: frame_done pulses at cycle 81 and every 80 thereafter.
2. Mid-frame, load 0x11111111 at cycle 30.
   - Check: digits_ready=0 until the boundary.
   - Check: digits 3-7 still show 4..8.
   - Check: the next frame shows all 1s; digits_ready returns to 1 one cycle after the boundary.
3. blank_lz=1 with frame 0x00000305.
   - Check: anodes 7..3 stay 1 for whole slots.
   - Check: digit 2 shows 3 and digit 1 shows 0 (not blanked, below a nonzero digit).
   - Check: frame 0x00000000 lights only digit 0.
4. Transfer asserted exactly on the boundary cycle with pending=0.
   - Check: the new data appears at index 0 of the immediately following frame.
   - Check: digits_ready stays 1.
5. enable dropped during SHOW of index 5.
   - Check: anode all 1 and frame_done=0 next cycle.
   - Check: re-enable restarts at index 0 with 2 blank cycles.
   - Check: a pending load is held until the first boundary.
6. rst_n pulsed low during SHOW.
   - Check: anode=0xFF, dp_out=1, and digits_ready=1 asynchronously.
   - Check: buffers cleared, so the next scan shows 0s.

Source files
------------

// File: rtl/seg7_scan_scheduler.sv
// Time-multiplexed 8-digit 7-segment scan scheduler with double-buffered BCD frame,
// per-slot all-off guard interval and optional leading-zero blanking.
module seg7_scan_scheduler #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      blank_lz,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      digits_valid,
  output logic                      digits_ready,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [3:0]                digit_out,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SHOW_CYCLES = TICK_DIV - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   active_q, active_d, staging_q, staging_d;
  logic [NUM_DIGITS-1:0]     active_dp_q, active_dp_d, staging_dp_q, staging_dp_d;
  logic                      pending_q, pending_d;
  logic                      ready_q, ready_d;
  logic [NUM_DIGITS-1:0]     anode_q, anode_d;
  logic [3:0]                digit_q, digit_d;
  logic                      dp_q, dp_d;
  logic                      frame_done_q, frame_done_d;

  logic                      xfer;
  logic                      boundary;
  logic                      zero_run;
  logic [NUM_DIGITS-1:0]     blanked;
  logic [NUM_DIGITS-1:0]     onehot;
  logic [3:0]                sel_nib;
  logic                      sel_dp;
  logic                      sel_blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      staging_q    <= '0;
      active_dp_q  <= '0;
      staging_dp_q <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      anode_q      <= '1;
      digit_q      <= 4'h0;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      staging_q    <= staging_d;
      active_dp_q  <= active_dp_d;
      staging_dp_q <= staging_dp_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      anode_q      <= anode_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    staging_d    = staging_q;
    active_dp_d  = active_dp_q;
    staging_dp_d = staging_dp_q;
    pending_d    = pending_q;
    anode_d      = '1;
    digit_d      = 4'h0;
    dp_d         = 1'b1;
    zero_run     = 1'b1;
    blanked      = '0;
    onehot       = '0;
    sel_nib      = 4'h0;
    sel_dp       = 1'b0;
    sel_blk      = 1'b0;

    xfer     = digits_valid && ready_q;
    boundary = enable && (state_q == SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

    // Slot sequencing: IDLE -> (BLANK -> SHOW) per digit
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Active buffer only changes at a frame boundary or while idle
    if (boundary && pending_q) begin
      active_d    = staging_q;
      active_dp_d = staging_dp_q;
      pending_d   = 1'b0;
    end else if (xfer && (boundary || state_q == IDLE)) begin
      active_d    = digits_in;
      active_dp_d = dp_in;
    end else if (xfer) begin
      staging_d    = digits_in;
      staging_dp_d = dp_in;
      pending_d    = 1'b1;
    end

    // Leading-zero run scanned from the most significant digit down
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run   = zero_run && (active_d[4*i +: 4] == 4'h0);
      blanked[i] = blank_lz && zero_run && (i != 0);
    end

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        sel_nib   = active_d[4*i +: 4];
        sel_dp    = active_dp_d[i];
        sel_blk   = blanked[i];
      end
    end

    if (state_d != IDLE) begin
      digit_d = sel_nib;
      dp_d    = sel_blk || !sel_dp;
      if (state_d == SHOW && !sel_blk) anode_d = ~onehot;
    end
  end

  assign ready_d      = !pending_d;
  assign frame_done_d = boundary;

  assign digits_ready = ready_q;
  assign anode        = anode_q;
  assign digit_out    = digit_q;
  assign dp_out       = dp_q;
  assign frame_done   = frame_done_q;

endmodule
